// File: rtl/ras_stack_ctrl.sv
// Return-address-stack controller.
// The top of stack lives in a register. Deeper entries spill into a dual-port
// BRAM (port A) that is used as a circular buffer. A single FILL state hides
// the BRAM's one-cycle registered read latency when an entry is pulled back in.
module ras_stack_ctrl #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 36,
    parameter int CNTW  = $clog2(DEPTH + 2)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_valid,
    input  logic [WIDTH-1:0]         push_addr,
    input  logic                     pop_valid,
    output logic                     ready,
    output logic [WIDTH-1:0]         top_addr,
    output logic                     top_valid,
    output logic [CNTW-1:0]          count,
    output logic                     overflow,
    output logic                     underflow,
    output logic                     mem_rea,
    output logic [$clog2(DEPTH)-1:0] mem_raddr,
    output logic                     mem_wea,
    output logic [$clog2(DEPTH)-1:0] mem_waddr,
    output logic [WIDTH-1:0]         mem_wdata,
    input  logic [WIDTH-1:0]         mem_rdata
);
    localparam int ADDR = $clog2(DEPTH);

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state_q, state_d;
    logic [ADDR-1:0]   sp_q, sp_d;          // next free BRAM slot, wraps mod DEPTH
    logic [CNTW-1:0]   stored_q, stored_d;  // entries currently held in BRAM
    logic [WIDTH-1:0]  tos_q, tos_d;
    logic              tv_q, tv_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              push_only, pop_only, tail;

    assign ready     = (state_q == IDLE) && !rst;
    assign push_only = ready && push_valid && !pop_valid;
    assign pop_only  = ready && pop_valid && !push_valid;
    assign tail      = ready && push_valid && pop_valid;

    assign top_addr  = tos_q;
    assign top_valid = tv_q;
    assign count     = stored_q + CNTW'(tv_q);
    assign overflow  = ovf_q;
    assign underflow = unf_q;

    // Next-state and BRAM port A strobes from the accepted request and state.
    always_comb begin
        state_d   = state_q;
        sp_d      = sp_q;
        stored_d  = stored_q;
        tos_d     = tos_q;
        tv_d      = tv_q;
        ovf_d     = 1'b0;
        unf_d     = 1'b0;
        mem_rea   = 1'b0;
        mem_raddr = '0;
        mem_wea   = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (state_q == FILL) begin
            // Read data from the pop's cycle is now on the BRAM output.
            tos_d   = mem_rdata;
            tv_d    = 1'b1;
            state_d = IDLE;
        end else if (tail) begin
            // Call-then-return collapses to a TOS replacement; nothing spills.
            tos_d = push_addr;
            tv_d  = 1'b1;
        end else if (push_only) begin
            if (tv_q) begin
                mem_wea   = 1'b1;
                mem_waddr = sp_q;
                mem_wdata = tos_q;
                sp_d      = sp_q + ADDR'(1);
                // A full buffer overwrites its oldest slot, which is the one at sp.
                if (stored_q == CNTW'(DEPTH))
                    ovf_d = 1'b1;
                else
                    stored_d = stored_q + CNTW'(1);
            end
            tos_d = push_addr;
            tv_d  = 1'b1;
        end else if (pop_only) begin
            if (stored_q != '0) begin
                mem_rea   = 1'b1;
                mem_raddr = sp_q - ADDR'(1);
                sp_d      = sp_q - ADDR'(1);
                stored_d  = stored_q - CNTW'(1);
                tv_d      = 1'b0;
                state_d   = FILL;
            end else if (tv_q) begin
                tv_d = 1'b0;
            end else begin
                unf_d = 1'b1;
            end
        end
    end

    // State registers; reset leaves BRAM contents alone and drops any pending fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sp_q     <= '0;
            stored_q <= '0;
            tos_q    <= '0;
            tv_q     <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sp_q     <= sp_d;
            stored_q <= stored_d;
            tos_q    <= tos_d;
            tv_q     <= tv_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end
endmodule

// File: tb/tb_ras_stack_ctrl.sv
// Bench for ras_stack_ctrl: directed scenarios then random traffic, all checked
// against a queue-based stack model that keeps the newest DEPTH+1 entries.
module tb_ras_stack_ctrl;
    localparam int DEPTH = 4;
    localparam int WIDTH = 32;
    localparam int CNTW  = $clog2(DEPTH + 2);
    localparam int ADDR  = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             push_valid = 1'b0;
    logic             pop_valid = 1'b0;
    logic [WIDTH-1:0] push_addr = '0;
    logic             ready, top_valid, overflow, underflow, mem_rea, mem_wea;
    logic [WIDTH-1:0] top_addr, mem_wdata;
    logic [CNTW-1:0]  count;
    logic [ADDR-1:0]  mem_raddr, mem_waddr;
    logic [WIDTH-1:0] bram [DEPTH];
    logic [WIDTH-1:0] rdata_q = '0;

    always #5 clk = ~clk;

    ras_stack_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .push_valid(push_valid), .push_addr(push_addr),
        .pop_valid(pop_valid), .ready(ready), .top_addr(top_addr),
        .top_valid(top_valid), .count(count), .overflow(overflow),
        .underflow(underflow), .mem_rea(mem_rea), .mem_raddr(mem_raddr),
        .mem_wea(mem_wea), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_rdata(rdata_q)
    );

    // BRAM port A with registered read.
    always @(posedge clk) begin
        if (mem_wea) bram[mem_waddr] <= mem_wdata;
        if (mem_rea) rdata_q <= bram[mem_raddr];
    end

    int passed = 0;
    int total  = 0;
    logic [WIDTH-1:0] stk[$];   // oldest at front, top at back
    bit               busy = 1'b0;  // refill in flight: TOS not yet visible
    logic [ADDR-1:0]  lw_addr = '0, lr_addr = '0;
    logic [WIDTH-1:0] lw_data = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock cycle: drive, check combinational strobes, clock, update model, check state.
    task automatic cyc(input bit r, input bit pu, input bit po, input logic [WIDTH-1:0] a);
        bit rdy, pu_only, po_only, tl, e_ovf, e_unf;
        int n;
        rst = r; push_valid = pu; pop_valid = po; push_addr = a;
        #1;
        n       = stk.size();
        rdy     = !r && !busy;
        pu_only = rdy && pu && !po;
        po_only = rdy && po && !pu;
        tl      = rdy && pu && po;
        chk("ready", ready, rdy);
        chk("mem_wea", mem_wea, pu_only && n > 0);
        chk("mem_rea", mem_rea, po_only && n > 1);
        chk("rea_wea_excl", mem_rea & mem_wea, 0);
        if (mem_wea) begin
            lw_addr = mem_waddr;
            lw_data = mem_wdata;
            if (n > 0) chk("mem_wdata", mem_wdata, stk[n-1]);
        end
        if (mem_rea) lr_addr = mem_raddr;
        @(posedge clk);
        #1;
        e_ovf = 1'b0;
        e_unf = 1'b0;
        if (r) begin
            stk.delete();
            busy = 1'b0;
        end else if (busy) begin
            busy = 1'b0;
        end else if (tl) begin
            if (n == 0) stk.push_back(a);
            else stk[n-1] = a;
        end else if (pu_only) begin
            stk.push_back(a);
            if (stk.size() > DEPTH + 1) begin
                void'(stk.pop_front());
                e_ovf = 1'b1;
            end
        end else if (po_only) begin
            if (n == 0) e_unf = 1'b1;
            else begin
                void'(stk.pop_back());
                busy = (n > 1);
            end
        end
        n = stk.size();
        chk("overflow", overflow, e_ovf);
        chk("underflow", underflow, e_unf);
        chk("top_valid", top_valid, !busy && n > 0);
        chk("count", count, busy ? n - 1 : n);
        if (!busy && n > 0) chk("top_addr", top_addr, stk[n-1]);
    endtask

    int exp_seq[4] = '{5, 4, 3, 2};
    int x;

    initial begin
        // Reset state
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("rst_top_addr", top_addr, 0);
        chk("rst_count", count, 0);

        // S1: three pushes spill the two older entries
        cyc(0, 1, 0, 'h100);
        cyc(0, 1, 0, 'h200);
        chk("s1_waddr0", lw_addr, 0);
        chk("s1_wdata0", lw_data, 'h100);
        cyc(0, 1, 0, 'h300);
        chk("s1_waddr1", lw_addr, 1);
        chk("s1_wdata1", lw_data, 'h200);
        chk("s1_top", top_addr, 'h300);
        chk("s1_count", count, 3);

        // S2: three pops, refills from slots 1 then 0, then empties
        cyc(0, 0, 1, 0);
        chk("s2_raddr1", lr_addr, 1);
        cyc(0, 0, 0, 0);
        chk("s2_top200", top_addr, 'h200);
        cyc(0, 0, 1, 0);
        chk("s2_raddr0", lr_addr, 0);
        cyc(0, 0, 0, 0);
        chk("s2_top100", top_addr, 'h100);
        cyc(0, 0, 1, 0);
        chk("s2_empty_tv", top_valid, 0);
        chk("s2_empty_cnt", count, 0);

        // S3: overflow on the sixth push, then drain
        cyc(1, 0, 0, 0);
        for (int i = 1; i <= 6; i++) cyc(0, 1, 0, i);
        chk("s3_waddr", lw_addr, 0);
        chk("s3_wdata", lw_data, 5);
        chk("s3_count", count, 5);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            chk("s3_pop_seq", top_addr, exp_seq[k]);
            cyc(0, 0, 1, 0);
            cyc(0, 0, 0, 0);
        end
        chk("s3_drained", top_valid, 0);

        // S4: pop while empty
        cyc(0, 0, 1, 0);
        chk("s4_underflow", underflow, 1);
        chk("s4_count", count, 0);
        cyc(0, 0, 0, 0);

        // S5: tail call with TOS=0xA0, count=2
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 'h10);
        cyc(0, 1, 0, 'hA0);
        cyc(0, 1, 1, 'hB0);
        chk("s5_top", top_addr, 'hB0);
        chk("s5_count", count, 2);

        // S6: reset lands during FILL
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 'h42);
        chk("s6_top", top_addr, 'h42);
        chk("s6_count", count, 1);

        // Random traffic
        cyc(1, 0, 0, 0);
        repeat (2000) begin
            x = $urandom_range(0, 99);
            if (x < 2)       cyc(1, 0, 0, 0);
            else if (x < 47) cyc(0, 1, 0, $urandom);
            else if (x < 87) cyc(0, 0, 1, 0);
            else if (x < 95) cyc(0, 1, 1, $urandom);
            else             cyc(0, 0, 0, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
